// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU with RV32M multiply/divide.
// Holds the ALU control decode so every stage sees one definition of the encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [6:0] FUNCT7_BASE   = 7'h00;
    localparam logic [6:0] FUNCT7_ALT    = 7'h20;
    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_op_e;

    // I-type has no SUBI: only funct7[5] matters there, and only for SRAI.
    function automatic alu_ctrl_e decode_alu(input logic [1:0] alu_op,
                                             input logic [2:0] f3,
                                             input logic [6:0] f7);
        logic alt;
        alt = (alu_op == ALUOP_RTYPE) ? (f7 == FUNCT7_ALT) : f7[5];
        case (alu_op)
            ALUOP_MEM:    return ALU_ADD;
            ALUOP_BRANCH: return ALU_SUB;
            default: begin
                case (f3)
                    3'b000:  return (alu_op == ALUOP_RTYPE && alt) ? ALU_SUB : ALU_ADD;
                    3'b001:  return ALU_SLL;
                    3'b010:  return ALU_SLT;
                    3'b011:  return ALU_SLTU;
                    3'b100:  return ALU_XOR;
                    3'b101:  return alt ? ALU_SRA : ALU_SRL;
                    3'b110:  return ALU_OR;
                    default: return ALU_AND;
                endcase
            end
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned datapath: shift-add multiply and restoring divide, one bit per cycle.
// Operands arrive as magnitudes; sign handling stays in the caller.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  md_op_e          op,
    input  logic [XLEN-1:0] a_abs,
    input  logic [XLEN-1:0] b_abs,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q;
    logic [CW-1:0]     cnt_q;
    logic              run_q;
    md_op_e            op_q;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic              fits;
    logic [XLEN-1:0]   rem_new;

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        acc_d   = acc_q;
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        fits    = (rem_sh >= {1'b0, opb_q});
        rem_new = fits ? (rem_sh[XLEN-1:0] - opb_q) : rem_sh[XLEN-1:0];
        if (op_q == MD_MUL)
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        else
            acc_d = {rem_new, acc_q[XLEN-2:0], fits};
    end

    assign done = run_q && (cnt_q == CW'(XLEN - 1));
    assign hi   = acc_q[2*XLEN-1:XLEN];
    assign lo   = acc_q[XLEN-1:0];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            acc_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            op_q  <= MD_MUL;
        end else if (start) begin
            acc_q <= {{XLEN{1'b0}}, a_abs};
            opb_q <= b_abs;
            cnt_q <= '0;
            run_q <= 1'b1;
            op_q  <= op;
        end else if (run_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            if (done)
                run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU: decodes ALUOp/funct3/funct7, runs basic ops in one cycle and
// RV32M ops through an iterative datapath, stalling issue via in_ready meanwhile.
module alu_muldiv_unit
    import alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            out_valid_q, out_valid_d;
    logic            want_hi_q, res_neg_q, is_mul_q;

    alu_ctrl_e       ctrl;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_out;

    logic            accept, is_m, is_mul, is_div;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            want_hi, res_neg;
    logic            div_by_zero, div_ovf, div_special;
    logic [XLEN-1:0] special_res;
    logic [2*XLEN-1:0] prod_fast;
    logic [XLEN-1:0] fast_res;
    logic            one_cycle, start_iter;
    logic [XLEN-1:0] quick_res;

    logic            md_done;
    logic [XLEN-1:0] md_hi, md_lo;
    logic [2*XLEN-1:0] full_prod, full_sel;
    logic [XLEN-1:0] div_raw, fix_res;

    // ---------------- decode and basic ALU ----------------
    assign ctrl  = decode_alu(ALUOp, funct3, funct7);
    assign shamt = b[SHW-1:0];

    always_comb begin
        alu_out = a + b;
        unique case (ctrl)
            ALU_ADD:  alu_out = a + b;
            ALU_SUB:  alu_out = a - b;
            ALU_AND:  alu_out = a & b;
            ALU_OR:   alu_out = a | b;
            ALU_XOR:  alu_out = a ^ b;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, a < b};
            ALU_SLL:  alu_out = a << shamt;
            ALU_SRL:  alu_out = a >> shamt;
            ALU_SRA:  alu_out = $unsigned($signed(a) >>> shamt);
            default:  alu_out = a + b;
        endcase
    end

    // ---------------- M-extension operand preparation ----------------
    assign accept = in_valid && in_ready;
    assign is_m   = (ALUOp == ALUOP_RTYPE) && (funct7 == FUNCT7_MULDIV);
    assign is_mul = is_m && !funct3[2];
    assign is_div = is_m &&  funct3[2];

    // MUL takes the low half, which is sign-agnostic, so it runs unsigned.
    assign a_signed = is_mul ? (funct3 == F3_MULH || funct3 == F3_MULHSU) : !funct3[0];
    assign b_signed = is_mul ? (funct3 == F3_MULH) : !funct3[0];
    assign a_neg    = a_signed && a[XLEN-1];
    assign b_neg    = b_signed && b[XLEN-1];
    assign a_abs    = a_neg ? -a : a;
    assign b_abs    = b_neg ? -b : b;

    assign want_hi  = is_mul ? (funct3 != F3_MUL) : funct3[1];
    assign res_neg  = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_by_zero = (b == '0);
    assign div_ovf     = a_signed && (a == MOST_NEG) && (b == '1);
    assign div_special = is_div && (div_by_zero || div_ovf);
    assign special_res = div_by_zero ? (funct3[1] ? a : '1)
                                     : (funct3[1] ? '0 : a);

    assign prod_fast = {{XLEN{a_neg}}, a} * {{XLEN{b_neg}}, b};
    assign fast_res  = want_hi ? prod_fast[2*XLEN-1:XLEN] : prod_fast[XLEN-1:0];

    assign one_cycle  = !is_m || div_special || (is_mul && FAST_MUL);
    assign start_iter = accept && is_m && !one_cycle;
    assign quick_res  = !is_m ? alu_out : (div_special ? special_res : fast_res);

    muldiv_iter #(.XLEN(XLEN)) u_muldiv_iter (
        .clk   (clk),
        .reset (reset),
        .start (start_iter),
        .op    (is_mul ? MD_MUL : MD_DIV),
        .a_abs (a_abs),
        .b_abs (b_abs),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // Multiply sign is applied to the whole product before choosing a half.
    assign full_prod = {md_hi, md_lo};
    assign full_sel  = res_neg_q ? -full_prod : full_prod;
    assign div_raw   = want_hi_q ? md_hi : md_lo;
    assign fix_res   = is_mul_q ? (want_hi_q ? full_sel[2*XLEN-1:XLEN] : full_sel[XLEN-1:0])
                                : (res_neg_q ? -div_raw : div_raw);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_iter) state_d = is_mul ? ST_MUL : ST_DIV;
            ST_MUL,
            ST_DIV:  if (md_done) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE);
        busy     = !in_ready;
    end

    // ---------------- result register ----------------
    always_comb begin
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        if (accept && one_cycle) begin
            result_d    = quick_res;
            zero_d      = (quick_res == '0);
            out_valid_d = 1'b1;
        end else if (state_q == ST_FIX) begin
            result_d    = fix_res;
            zero_d      = (fix_res == '0);
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            want_hi_q   <= 1'b0;
            res_neg_q   <= 1'b0;
            is_mul_q    <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            if (start_iter) begin
                want_hi_q <= want_hi;
                res_neg_q <= res_neg;
                is_mul_q  <= is_mul;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed-vector bench for alu_muldiv_unit (XLEN=32, iterative multiply).
// Expected results and latencies are hand-computed constants.
module tb_alu_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    alu_muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUOp     (ALUOp),
        .funct3    (funct3),
        .funct7    (funct7),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, then count cycles after the accept edge until out_valid.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_res, input int exp_lat, input int glitch_at);
        int  n;
        int  ready_hi;
        bit  seen;
        ALUOp = op; funct3 = f3; funct7 = f7; a = av; b = bv;
        in_valid = 1'b1;
        check({tag, ":ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1; ready_hi = 0; seen = 1'b0;
        while (n <= 100 && !seen) begin
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                if (in_ready || !busy) ready_hi++;
                if (n == glitch_at) begin
                    in_valid = 1'b1; ALUOp = 2'b00; a = 32'd1; b = 32'd1;
                end else begin
                    in_valid = 1'b0;
                end
                @(posedge clk); #1;
                n++;
            end
        end
        check({tag, ":lat"}, seen ? n : -1, exp_lat);
        check({tag, ":res"}, result, exp_res);
        check({tag, ":zero"}, {31'b0, zero}, {31'b0, exp_res == 32'd0});
        if (exp_lat > 1)
            check({tag, ":stall"}, ready_hi, 32'd0);
    endtask

    initial begin
        int ov_cnt;
        reset = 1'b1; in_valid = 1'b0;
        ALUOp = 2'b00; funct3 = 3'b000; funct7 = 7'h00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst:in_ready",  {31'b0, in_ready},  32'd1);
        check("rst:busy",      {31'b0, busy},      32'd0);
        check("rst:out_valid", {31'b0, out_valid}, 32'd0);
        check("rst:result",    result,             32'd0);
        check("rst:zero",      {31'b0, zero},      32'd1);

        // Basic ALU
        run_op("sub",   2'b10, 3'b000, 7'h20, 32'd5,        32'd7,        32'hFFFFFFFE, 1, 0);
        run_op("beq",   2'b01, 3'b000, 7'h00, 32'h1234,     32'h1234,     32'h00000000, 1, 0);
        run_op("srai",  2'b11, 3'b101, 7'h20, 32'h80000000, 32'd4,        32'hF8000000, 1, 0);
        run_op("srli",  2'b11, 3'b101, 7'h00, 32'h80000000, 32'd4,        32'h08000000, 1, 0);
        run_op("addi",  2'b11, 3'b000, 7'h20, 32'd1,        32'd1,        32'h00000002, 1, 0);
        run_op("slt",   2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1, 0);
        run_op("sltu",  2'b10, 3'b011, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1, 0);
        run_op("and",   2'b10, 3'b111, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1, 0);
        run_op("sll",   2'b10, 3'b001, 7'h00, 32'd1,        32'h23,       32'h00000008, 1, 0);
        run_op("ldadd", 2'b00, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1, 0);

        // Iterative multiply, with an ignored request mid-flight
        run_op("mul",    2'b10, 3'b000, 7'h01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 34, 5);
        @(posedge clk); #1;
        check("mul:noqueue", {31'b0, out_valid}, 32'd0);
        run_op("mulh",   2'b10, 3'b001, 7'h01, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
        run_op("mulhu",  2'b10, 3'b011, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
        run_op("mulhsu", 2'b10, 3'b010, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0);

        // Iterative divide, last two issued back-to-back in the completion cycle
        run_op("div",  2'b10, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 0);
        run_op("rem",  2'b10, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 0);
        run_op("divu", 2'b10, 3'b101, 7'h01, 32'd100,      32'd7, 32'd14,       34, 0);
        run_op("remu", 2'b10, 3'b111, 7'h01, 32'd100,      32'd7, 32'd2,        34, 0);

        // Division special cases
        run_op("divu0", 2'b10, 3'b101, 7'h01, 32'h55,       32'd0,        32'hFFFFFFFF, 1, 0);
        run_op("remu0", 2'b10, 3'b111, 7'h01, 32'h55,       32'd0,        32'h00000055, 1, 0);
        run_op("div0",  2'b10, 3'b100, 7'h01, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1, 0);
        run_op("rem0",  2'b10, 3'b110, 7'h01, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1, 0);
        run_op("divov", 2'b10, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_op("remov", 2'b10, 3'b110, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0);

        // Reset during a divide aborts it cleanly
        ALUOp = 2'b10; funct3 = 3'b100; funct7 = 7'h01; a = 32'd100; b = 32'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort:busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort:in_ready", {31'b0, in_ready}, 32'd1);
        check("abort:busy",     {31'b0, busy},     32'd0);
        check("abort:result",   result,            32'd0);
        check("abort:zero",     {31'b0, zero},     32'd1);
        ov_cnt = out_valid ? 1 : 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) ov_cnt++;
        end
        check("abort:no_valid", ov_cnt, 32'd0);
        run_op("add_after", 2'b10, 3'b000, 7'h00, 32'd2, 32'd3, 32'd5, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
